// File: rtl/overcooked_pkg.sv
// Shared types and helpers for the player input scheduler.
// Holds the action word layout, FSM states and slot/accumulation helpers.
package overcooked_pkg;

    localparam int ACT_W = 6;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
        logic chop;
        logic carry;
    } action_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNAP  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Motion/chop bits are sticky; carry is a level, so the newest sample wins.
    function automatic action_t accumulate(action_t pend, logic vld, action_t act);
        action_t r;
        if (vld) begin
            r       = pend | act;
            r.carry = act.carry;
        end else begin
            r = pend;
        end
        return r;
    endfunction

    function automatic logic [1:0] next_slot(logic [1:0] cur, logic [2:0] n_act);
        logic [1:0] r;
        if (({1'b0, cur} + 3'd1) >= n_act) begin
            r = 2'd0;
        end else begin
            r = cur + 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; the pulse lands one cycle after the input rises.
module edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic rise
);
    logic in_q;
    logic rise_q;
    logic rise_d;

    always_comb begin
        rise_d = in & ~in_q;
    end

    // Delay line for the input and the registered edge pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            in_q   <= in;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;
endmodule

// File: rtl/player_input_scheduler.sv
// Collects per-player button events between frames and hands one snapshotted
// slot per handshake to game_logic, rotating the first slot every frame.
module player_input_scheduler
    import overcooked_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 16,
    parameter int DROP_W    = 8
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                vsync,
    input  logic [1:0]                          num_players,
    input  logic [NUM_SLOTS-1:0]                in_valid,
    input  logic [NUM_SLOTS-1:0][ACT_W-1:0]     in_action,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [1:0]                          out_player_id,
    output logic [ACT_W-1:0]                    out_action,
    output logic                                frame_done,
    output logic                                frame_overrun,
    output logic [DROP_W-1:0]                   drop_count,
    output logic                                busy
);
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic         vs_rise;
    sched_state_t state_q, state_d;
    action_t      pend_q [NUM_SLOTS];
    action_t      pend_d [NUM_SLOTS];
    action_t      snap_q [NUM_SLOTS];
    action_t      snap_d [NUM_SLOTS];
    logic [2:0]   n_act_q, n_act_d;
    logic [1:0]   cur_q, cur_d;
    logic [1:0]   start_q, start_d;
    logic [2:0]   served_q, served_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [1:0]   start_eff;
    logic [1:0]   nxt;
    logic         out_valid_q, out_valid_d;
    logic [1:0]   out_player_id_q, out_player_id_d;
    action_t      out_action_q, out_action_d;
    logic         frame_done_q, frame_done_d;
    logic         frame_overrun_q, frame_overrun_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic         busy_q, busy_d;

    edge_detect u_vsync_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (vsync),
        .rise    (vs_rise)
    );

    // Next-state logic: accumulation, snapshot and the round-robin issue loop.
    always_comb begin
        state_d         = state_q;
        n_act_d         = n_act_q;
        cur_d           = cur_q;
        start_d         = start_q;
        served_d        = served_q;
        tcnt_d          = tcnt_q;
        out_valid_d     = out_valid_q;
        out_player_id_d = out_player_id_q;
        out_action_d    = out_action_q;
        drop_count_d    = drop_count_q;
        frame_done_d    = 1'b0;
        frame_overrun_d = vs_rise && (state_q != IDLE);
        start_eff       = 2'd0;
        nxt             = next_slot(cur_q, n_act_q);
        for (int p = 0; p < NUM_SLOTS; p++) begin
            pend_d[p] = accumulate(pend_q[p], in_valid[p], action_t'(in_action[p]));
            snap_d[p] = snap_q[p];
        end

        case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    state_d = SNAP;
                end else begin
                    state_d = IDLE;
                end
            end
            SNAP: begin
                for (int p = 0; p < NUM_SLOTS; p++) begin
                    snap_d[p] = pend_d[p];
                    pend_d[p] = action_t'({{(ACT_W-1){1'b0}}, pend_d[p].carry});
                end
                n_act_d = {1'b0, num_players} + 3'd1;
                // A shrunk player count can leave the rotation pointer out of range.
                if ({1'b0, start_q} >= n_act_d) begin
                    start_eff = 2'd0;
                end else begin
                    start_eff = start_q;
                end
                start_d         = start_eff;
                cur_d           = start_eff;
                served_d        = 3'd0;
                tcnt_d          = {TCW{1'b0}};
                out_valid_d     = 1'b1;
                out_player_id_d = start_eff;
                out_action_d    = snap_d[start_eff];
                state_d         = ISSUE;
            end
            ISSUE: begin
                if (out_ready || (tcnt_q == TCW'(TIMEOUT - 1))) begin
                    if (!out_ready && (drop_count_q != {DROP_W{1'b1}})) begin
                        drop_count_d = drop_count_q + {{(DROP_W-1){1'b0}}, 1'b1};
                    end else begin
                        drop_count_d = drop_count_q;
                    end
                    tcnt_d = {TCW{1'b0}};
                    if ((served_q + 3'd1) == n_act_q) begin
                        out_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        served_d        = served_q + 3'd1;
                        cur_d           = nxt;
                        out_player_id_d = nxt;
                        out_action_d    = snap_q[nxt];
                        state_d         = ISSUE;
                    end
                end else begin
                    tcnt_d = tcnt_q + {{(TCW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                start_d = next_slot(start_q, n_act_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            n_act_q         <= 3'd0;
            cur_q           <= 2'd0;
            start_q         <= 2'd0;
            served_q        <= 3'd0;
            tcnt_q          <= {TCW{1'b0}};
            out_valid_q     <= 1'b0;
            out_player_id_q <= 2'd0;
            out_action_q    <= '0;
            frame_done_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
            drop_count_q    <= {DROP_W{1'b0}};
            busy_q          <= 1'b0;
            for (int p = 0; p < NUM_SLOTS; p++) begin
                pend_q[p] <= '0;
                snap_q[p] <= '0;
            end
        end else begin
            state_q         <= state_d;
            n_act_q         <= n_act_d;
            cur_q           <= cur_d;
            start_q         <= start_d;
            served_q        <= served_d;
            tcnt_q          <= tcnt_d;
            out_valid_q     <= out_valid_d;
            out_player_id_q <= out_player_id_d;
            out_action_q    <= out_action_d;
            frame_done_q    <= frame_done_d;
            frame_overrun_q <= frame_overrun_d;
            drop_count_q    <= drop_count_d;
            busy_q          <= busy_d;
            for (int p = 0; p < NUM_SLOTS; p++) begin
                pend_q[p] <= pend_d[p];
                snap_q[p] <= snap_d[p];
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_player_id = out_player_id_q;
    assign out_action    = out_action_q;
    assign frame_done    = frame_done_q;
    assign frame_overrun = frame_overrun_q;
    assign drop_count    = drop_count_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_player_input_scheduler.sv
// Directed bench for player_input_scheduler: a frame-level model predicts every
// presented slot, plus literal checks on order, latency, drops, overrun and reset.
module tb_player_input_scheduler;
    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            vsync = 1'b0;
    logic [1:0]      num_players = 2'd0;
    logic [3:0]      in_valid = 4'd0;
    logic [3:0][5:0] in_action = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [1:0]      out_player_id;
    logic [5:0]      out_action;
    logic            frame_done;
    logic            frame_overrun;
    logic [7:0]      drop_count;
    logic            busy;

    player_input_scheduler dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .vsync         (vsync),
        .num_players   (num_players),
        .in_valid      (in_valid),
        .in_action     (in_action),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_player_id (out_player_id),
        .out_action    (out_action),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model state
    logic [5:0] m_pend [4];
    int         q_id [$];
    logic [5:0] q_act [$];
    bit         issuing, done_pend, mbusy, exp_fd, vprev;
    int         cd, wait_c, m_start, m_drops;

    // Observations collected by the compare process
    int         obs_id [$];
    logic [5:0] obs_act [$];
    bit         fd_seen, fv_seen;
    int         fd_cyc, fv_cyc, e_cyc, ovr_cnt = 0;

    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                for (int p = 0; p < 4; p++) m_pend[p] = 6'd0;
                q_id.delete(); q_act.delete();
                issuing = 0; done_pend = 0; mbusy = 0; exp_fd = 0; vprev = 0;
                cd = 0; wait_c = 0; m_start = 0; m_drops = 0;
            end else begin
                bit pop;
                exp_fd = 0;
                if (done_pend) begin mbusy = 0; done_pend = 0; end
                if (issuing && q_id.size() > 0) begin
                    pop = 0;
                    if (out_ready) pop = 1;
                    else begin
                        wait_c++;
                        if (wait_c == 16) begin
                            pop = 1;
                            if (m_drops < 255) m_drops++;
                        end
                    end
                    if (pop) begin
                        void'(q_id.pop_front()); void'(q_act.pop_front());
                        wait_c = 0;
                        if (q_id.size() == 0) begin issuing = 0; done_pend = 1; exp_fd = 1; end
                    end
                end
                for (int p = 0; p < 4; p++) begin
                    if (in_valid[p]) begin
                        m_pend[p][5:1] = m_pend[p][5:1] | in_action[p][5:1];
                        m_pend[p][0]   = in_action[p][0];
                    end
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        int n, s;
                        n = int'(num_players) + 1;
                        s = (m_start >= n) ? 0 : m_start;
                        for (int k = 0; k < n; k++) begin
                            q_id.push_back((s + k) % n);
                            q_act.push_back(m_pend[(s + k) % n]);
                        end
                        for (int p = 0; p < 4; p++) m_pend[p][5:1] = 5'd0;
                        m_start = (s + 1) % n;
                        issuing = 1; wait_c = 0;
                    end
                end
                if (vsync && !vprev && !mbusy) begin mbusy = 1; cd = 2; end
                vprev = vsync;
            end
        end
    end

    // Compare process: checks DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                bit ev;
                ev = issuing && (q_id.size() > 0);
                chk("out_valid", int'(out_valid), int'(ev));
                if (ev && out_valid) begin
                    chk("out_player_id", int'(out_player_id), q_id[0]);
                    chk("out_action", int'(out_action), int'(q_act[0]));
                end
                chk("frame_done", int'(frame_done), int'(exp_fd));
                chk("drop_count", int'(drop_count), m_drops);
                if (out_valid && out_ready) begin
                    obs_id.push_back(int'(out_player_id));
                    obs_act.push_back(out_action);
                end
                if (out_valid && !fv_seen) begin fv_seen = 1; fv_cyc = cyc; end
                if (frame_done) begin fd_seen = 1; fd_cyc = cyc; end
                if (frame_overrun) ovr_cnt++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic pulse(input int p, input logic [5:0] a);
        in_valid[p] = 1'b1; in_action[p] = a;
        tick();
        in_valid[p] = 1'b0; in_action[p] = 6'd0;
    endtask

    task automatic start_frame();
        obs_id.delete(); obs_act.delete();
        fd_seen = 0; fv_seen = 0;
        vsync = 1'b1; e_cyc = cyc + 1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !fd_seen; i++) tick();
        chk("frame_done_within_budget", int'(fd_seen), 1);
        tick(2);
    endtask

    function automatic int order_code();
        int r = 0;
        foreach (obs_id[i]) r = r * 10 + obs_id[i];
        return r;
    endfunction

    initial begin
        int ovr0;
        tick(2);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_drop_count", int'(drop_count), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        reset_n = 1'b1;
        tick(2);

        // Four players, P2 left, ready held high
        num_players = 2'd3; out_ready = 1'b1;
        pulse(2, 6'b100000);
        start_frame();
        wait_done(30);
        chk("f1_order", order_code(), 123);
        chk("f1_p2_action", int'(obs_act[2]), 6'b100000);
        chk("f1_p0_action", int'(obs_act[0]), 0);
        chk("f1_first_valid_latency", fv_cyc - e_cyc, 2);
        chk("f1_frame_done_latency", fd_cyc - e_cyc, 6);

        start_frame(); wait_done(30);
        chk("f2_order", order_code(), 1230);
        chk("f2_p2_motion_cleared", int'(obs_act[1]), 0);
        start_frame(); wait_done(30);
        chk("f3_order", order_code(), 2301);

        // Two players, ready held low: both slots time out
        num_players = 2'd1; out_ready = 1'b0;
        start_frame(); wait_done(60);
        chk("f4_drop_count", int'(drop_count), 2);
        chk("f4_accepted", obs_id.size(), 0);
        chk("f4_frame_done_latency", fd_cyc - e_cyc, 34);

        // Second vsync edge while issuing
        ovr0 = ovr_cnt;
        start_frame();
        tick(4);
        pulse(0, 6'b000010);
        vsync = 1'b1; tick(); vsync = 1'b0;
        tick(3);
        out_ready = 1'b1;
        wait_done(40);
        chk("f5_overrun_pulses", ovr_cnt - ovr0, 1);
        chk("f5_order_no_restart", order_code(), 10);
        chk("f5_drop_count", int'(drop_count), 2);
        start_frame(); wait_done(30);
        chk("f6_order", order_code(), 1);
        chk("f6_p0_chop", int'(obs_act[0]), 6'b000010);

        // Carry is a level: last value wins and persists across frames
        num_players = 2'd3;
        pulse(3, 6'b000001);
        pulse(1, 6'b000001);
        pulse(1, 6'b000000);
        start_frame(); wait_done(30);
        chk("f7_order", order_code(), 1230);
        chk("f7_p1_carry0", int'(obs_act[0]), 0);
        chk("f7_p3_carry1", int'(obs_act[2]), 1);
        start_frame(); wait_done(30);
        chk("f8_order", order_code(), 2301);
        chk("f8_p3_carry_kept", int'(obs_act[1]), 1);
        chk("f8_p1_idle", int'(obs_act[3]), 0);

        // Reset in the middle of issue
        out_ready = 1'b0;
        start_frame();
        tick(4);
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_valid", int'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_out_valid", int'(out_valid), 0);
        chk("reset_mid_busy", int'(busy), 0);
        chk("reset_mid_drop_count", int'(drop_count), 0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick(2);
        start_frame(); wait_done(30);
        chk("f9_order_from_zero", order_code(), 123);
        chk("f9_p3_carry_cleared", int'(obs_act[3]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
